axis_pkt_fifo: RTL and testbench



---
 rtl/axis_fifo_pkg.sv | 18 +
 rtl/axis_fifo_ram.sv | 24 ++
 rtl/axis_pkt_fifo.sv | 90 +++++++++
 tb/tb_axis_pkt_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI4-Stream packet FIFO: pointer arithmetic and word packing.
package axis_fifo_pkg;

  localparam int unsigned PTR_MAX   = 13;
  localparam int unsigned LAST_BITS = 1;

  // Stored word is {tlast, tdata}.
  function automatic int unsigned word_width(input int unsigned width);
    return width + LAST_BITS;
  endfunction

  // Modulo difference of two wrap-around pointers; caller truncates to its pointer width.
  function automatic logic [PTR_MAX-1:0] ptr_diff(input logic [PTR_MAX-1:0] a,
                                                  input logic [PTR_MAX-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read (LUT/SSRAM friendly).
module axis_fifo_ram #(
  parameter int unsigned DW    = 9,
  parameter int unsigned ABITS = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ABITS-1:0] i_waddr,
  input  logic [DW-1:0]    i_wdata,
  input  logic [ABITS-1:0] i_raddr,
  output logic [DW-1:0]    o_rdata
);

  localparam int unsigned DEPTH = 1 << ABITS;

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward packet mode and oversize release.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ABITS       = 4,
  parameter int unsigned PACKET_MODE = 0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic [ABITS:0]   level_o,
  output logic             oversize_o
);

  localparam int unsigned DEPTH = 1 << ABITS;
  localparam int unsigned PW    = ABITS + 1;
  localparam int unsigned DW    = word_width(WIDTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_cm_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_cut;
  logic          r_oversize;

  logic [PW-1:0] w_level;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;
  logic          w_force;
  logic [DW-1:0] w_rdata;

  assign w_level = PW'(ptr_diff(PTR_MAX'(r_wr_ptr), PTR_MAX'(r_rd_ptr)));
  assign w_full  = (w_level == PW'(DEPTH));
  assign w_wr    = s_tvalid_i && !w_full;
  assign w_rd    = (r_cm_ptr != r_rd_ptr) && m_tready_i;
  // Whole buffer holds one unfinished packet: release it rather than deadlock.
  assign w_force = (PACKET_MODE != 0) && w_full && (r_cm_ptr == r_rd_ptr);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cut      <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      r_oversize <= w_force;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (PACKET_MODE == 0) begin
        if (w_wr) r_cm_ptr <= r_wr_ptr + PW'(1);
      end else if (w_force) begin
        r_cm_ptr <= r_wr_ptr;
        r_cut    <= 1'b1;
      end else if (w_wr && (s_tlast_i || r_cut)) begin
        // After a forced release the rest of that packet is cut-through until tlast.
        r_cm_ptr <= r_wr_ptr + PW'(1);
        r_cut    <= !s_tlast_i;
      end
    end
  end

  axis_fifo_ram #(
    .DW    (DW),
    .ABITS (ABITS)
  ) u_ram (
    .i_clk   (aclk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[ABITS-1:0]),
    .i_wdata ({s_tlast_i, s_tdata_i}),
    .i_raddr (r_rd_ptr[ABITS-1:0]),
    .o_rdata (w_rdata)
  );

  assign s_tready_o = !w_full;
  assign m_tvalid_o = (r_cm_ptr != r_rd_ptr);
  assign m_tdata_o  = w_rdata[WIDTH-1:0];
  assign m_tlast_o  = w_rdata[WIDTH];
  assign level_o    = w_level;
  assign oversize_o = r_oversize;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Drives a stream-mode and a packet-mode FIFO in lockstep against queue-based reference models.
module tb_axis_pkt_fifo;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       s_tvalid;
  logic       s_tlast;
  logic [7:0] s_tdata;
  logic       m_tready;

  logic       s_tready_s, m_tvalid_s, m_tlast_s, ov_s;
  logic [7:0] m_tdata_s;
  logic [4:0] level_s;
  logic       s_tready_p, m_tvalid_p, m_tlast_p, ov_p;
  logic [7:0] m_tdata_p;
  logic [4:0] level_p;

  always #5 aclk = ~aclk;

  axis_pkt_fifo #(.WIDTH(8), .ABITS(4), .PACKET_MODE(0)) u_dut_s (
    .aclk (aclk), .aresetn (aresetn),
    .s_tvalid_i (s_tvalid), .s_tready_o (s_tready_s), .s_tlast_i (s_tlast), .s_tdata_i (s_tdata),
    .m_tvalid_o (m_tvalid_s), .m_tready_i (m_tready), .m_tlast_o (m_tlast_s), .m_tdata_o (m_tdata_s),
    .level_o (level_s), .oversize_o (ov_s)
  );

  axis_pkt_fifo #(.WIDTH(8), .ABITS(4), .PACKET_MODE(1)) u_dut_p (
    .aclk (aclk), .aresetn (aresetn),
    .s_tvalid_i (s_tvalid), .s_tready_o (s_tready_p), .s_tlast_i (s_tlast), .s_tdata_i (s_tdata),
    .m_tvalid_o (m_tvalid_p), .m_tready_i (m_tready), .m_tlast_o (m_tlast_p), .m_tdata_o (m_tdata_p),
    .level_o (level_p), .oversize_o (ov_p)
  );

  // Reference state: stored beats per DUT; packet mode also tracks readable count.
  logic [8:0] q_s[$];
  logic [8:0] q_p[$];
  int         c_p;
  bit         cut_p;
  bit         ov_exp;
  int         n_ov;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("s_tready", 32'(s_tready_s), 32'(q_s.size() < 16));
    chk("s_tvalid", 32'(m_tvalid_s), 32'(q_s.size() > 0));
    chk("s_level", 32'(level_s), 32'(q_s.size()));
    chk("s_oversize", 32'(ov_s), 32'(0));
    if (q_s.size() > 0) chk("s_beat", 32'({m_tlast_s, m_tdata_s}), 32'(q_s[0]));
    chk("p_tready", 32'(s_tready_p), 32'(q_p.size() < 16));
    chk("p_tvalid", 32'(m_tvalid_p), 32'(c_p > 0));
    chk("p_level", 32'(level_p), 32'(q_p.size()));
    chk("p_oversize", 32'(ov_p), 32'(ov_exp));
    if (c_p > 0) chk("p_beat", 32'({m_tlast_p, m_tdata_p}), 32'(q_p[0]));
    if (ov_p === 1'b1) n_ov++;
  endtask

  task automatic tick(input bit sv, input bit sl, input logic [7:0] sd, input bit mr,
                      output bit wr_p);
    bit wr_s, rd_s, rd_p, force_p;
    s_tvalid = sv;
    s_tlast  = sl;
    s_tdata  = sd;
    m_tready = mr;
    check_outputs();
    wr_s    = sv && (q_s.size() < 16);
    rd_s    = mr && (q_s.size() > 0);
    wr_p    = sv && (q_p.size() < 16);
    rd_p    = mr && (c_p > 0);
    force_p = (q_p.size() == 16) && (c_p == 0);
    @(posedge aclk);
    #1;
    if (rd_s) void'(q_s.pop_front());
    if (wr_s) q_s.push_back({sl, sd});
    if (rd_p) begin
      void'(q_p.pop_front());
      c_p--;
    end
    if (wr_p) begin
      q_p.push_back({sl, sd});
      if (sl) begin
        c_p   = q_p.size();
        cut_p = 1'b0;
      end else if (cut_p) begin
        c_p++;
      end
    end
    ov_exp = force_p;
    if (force_p) begin
      c_p   = q_p.size();
      cut_p = 1'b1;
    end
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    q_s.delete();
    q_p.delete();
    c_p    = 0;
    cut_p  = 1'b0;
    ov_exp = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    int idx;
    do_reset();
    do_reset();

    // Reset state.
    chk("rst_tready", 32'(s_tready_s), 32'(1));
    chk("rst_tvalid", 32'(m_tvalid_p), 32'(0));
    chk("rst_level", 32'(level_p), 32'(0));

    // Random traffic at 50% valid / ready.
    for (int i = 0; i < 400; i++)
      tick($urandom % 2 == 0, $urandom % 4 == 0, 8'($urandom), $urandom % 2 == 0, w);
    repeat (40) tick(1'b0, 1'b0, 8'h00, 1'b1, w);

    // Repeated fill-to-full across pointer wrap.
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 16; i++)
        tick(1'b1, (f % 2 == 0) && (i == 15), 8'($urandom), 1'b0, w);
      chk("fill_full_tready", 32'(s_tready_s), 32'(0));
      chk("fill_full_level", 32'(level_s), 32'(16));
      tick(1'b1, 1'b0, 8'($urandom), 1'b1, w);
      chk("fill_rd_tready", 32'(s_tready_s), 32'(1));
      chk("fill_rd_level", 32'(level_s), 32'(15));
      repeat (20) tick(1'b0, 1'b0, 8'h00, 1'b1, w);
      chk("fill_drained", 32'(level_s), 32'(0));
    end

    // Five-beat packet 0x10..0x14.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, i == 4, 8'(8'h10 + i), 1'b0, w);
      chk("pkt5_tvalid", 32'(m_tvalid_p), 32'(i == 4));
    end
    repeat (6) tick(1'b0, 1'b0, 8'h00, 1'b1, w);
    chk("pkt5_drained", 32'(level_p), 32'(0));

    // Twenty-beat packet with tlast only at the end: forced release.
    do_reset();
    n_ov = 0;
    idx  = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      tick(idx < 20, idx == 19, 8'(8'h40 + idx), cyc >= 20, w);
      if (w) idx++;
    end
    chk("pkt20_accepted", 32'(idx), 32'(20));
    chk("pkt20_ov_pulses", 32'(n_ov), 32'(1));
    chk("pkt20_drained", 32'(level_p), 32'(0));

    // Sustained simultaneous read and write at level 8.
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, i == 7, 8'($urandom), 1'b0, w);
    for (int i = 0; i < 32; i++) begin
      tick(1'b1, 1'b1, 8'($urandom), 1'b1, w);
      chk("lvl8_p", 32'(level_p), 32'(8));
      chk("lvl8_s", 32'(level_s), 32'(8));
    end
    repeat (12) tick(1'b0, 1'b0, 8'h00, 1'b1, w);

    // Reset mid-packet, then a clean packet.
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, w);
    chk("mid_level", 32'(level_p), 32'(7));
    do_reset();
    chk("mid_rst_level", 32'(level_p), 32'(0));
    chk("mid_rst_tvalid", 32'(m_tvalid_p), 32'(0));
    chk("mid_rst_tready", 32'(s_tready_p), 32'(1));
    chk("mid_rst_tvalid_s", 32'(m_tvalid_s), 32'(0));
    for (int i = 0; i < 3; i++) tick(1'b1, i == 2, 8'(8'hC0 + i), 1'b0, w);
    chk("new_pkt_head", 32'({m_tlast_p, m_tdata_p}), 32'(9'h0C0));
    repeat (5) tick(1'b0, 1'b0, 8'h00, 1'b1, w);
    chk("new_pkt_drained", 32'(level_p), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
